// File: rtl/ep_memmux_if.sv
// Bus bundle for ep_memmux: SDRAM request port, CPU port, host download port and boot ROM port.
interface ep_memmux_if #(
    parameter int AW = 17
);
    logic          ready;
    logic          ce;
    logic          rfsh;
    logic          romIo;
    logic [21:0]   romA;
    logic [7:0]    romD;
    logic          romW;
    logic [21:0]   memA;
    logic [7:0]    memD;
    logic          memR;
    logic          memW;
    logic [7:0]    maxram;
    logic [AW-1:0] initA;
    logic [7:0]    initD;
    logic          sdrRf;
    logic          sdrRd;
    logic          sdrWr;
    logic [23:0]   sdrA;
    logic [15:0]   sdrD;
    logic [15:0]   sdrQ;
    logic [7:0]    memQ;
    logic          busy;
    logic [7:0]    romP;

    modport slave (
        input  ready, ce, rfsh, romIo, romA, romD, romW,
        input  memA, memD, memR, memW, maxram, initD, sdrQ,
        output initA, sdrRf, sdrRd, sdrWr, sdrA, sdrD, memQ, busy, romP
    );

    modport master (
        output ready, ce, rfsh, romIo, romA, romD, romW,
        output memA, memD, memR, memW, maxram, initD, sdrQ,
        input  initA, sdrRf, sdrRd, sdrWr, sdrA, sdrD, memQ, busy, romP
    );
endinterface

// File: rtl/ep_memmux.sv
// Boot-copy and SDRAM request multiplexer: copies the boot ROM into SDRAM, then muxes host downloads
// and CPU accesses onto the SDRAM port. Define EP_ROMDL_EN to include the host download path.
module ep_memmux #(
    parameter int          INIT_KB    = 128,
    parameter logic [7:0]  RESET_ROMP = 8'd7
) (
    input  logic        clock,
    input  logic        reset,
    ep_memmux_if.slave  bus
);
    localparam int          AW   = $clog2(INIT_KB * 1024);
    localparam logic [AW-1:0] LAST = AW'(INIT_KB * 1024 - 1);

    localparam logic [1:0] S_WAIT  = 2'd0;
    localparam logic [1:0] S_FETCH = 2'd1;
    localparam logic [1:0] S_WRITE = 2'd2;
    localparam logic [1:0] S_RUN   = 2'd3;

    logic [1:0]    r_state;
    logic [AW-1:0] r_cnt;
    logic [7:0]    r_romP;

    logic [7:0]    w_page;
    logic          w_ram;
    logic          w_rom;
    logic          w_hit;
    logic          w_sdrRf;
    logic          w_sdrRd;
    logic          w_sdrWr;
    logic [23:0]   w_sdrA;
    logic [15:0]   w_sdrD;
    logic          w_unused;

    // Losing ready restarts the copy from address 0 without waiting for ce.
    always_ff @(posedge clock) begin
        if (reset || !bus.ready) begin
            r_state <= S_WAIT;
            r_cnt   <= '0;
        end else begin
            case (r_state)
                S_WAIT: begin
                    r_state <= S_FETCH;
                    r_cnt   <= '0;
                end
                S_FETCH: begin
                    if (bus.ce) r_state <= S_WRITE;
                end
                S_WRITE: begin
                    if (bus.ce) begin
                        if (r_cnt == LAST) begin
                            r_state <= S_RUN;
                        end else begin
                            r_cnt   <= r_cnt + AW'(1);
                            r_state <= S_FETCH;
                        end
                    end
                end
                default: r_state <= S_RUN;
            endcase
        end
    end

`ifdef EP_ROMDL_EN
    always_ff @(posedge clock) begin
        if (reset)          r_romP <= RESET_ROMP;
        else if (bus.romIo) r_romP <= {5'd0, bus.romA[16:14]};
    end
    assign w_unused = ^bus.sdrQ[15:8];
`else
    assign r_romP   = RESET_ROMP;
    assign w_unused = ^{bus.sdrQ[15:8], bus.romIo, bus.romA, bus.romD, bus.romW};
`endif

    assign w_page = bus.memA[21:14];
    assign w_ram  = (w_page >= bus.maxram);
    assign w_rom  = (w_page <= r_romP);
    assign w_hit  = w_ram | w_rom;

    always_comb begin
        w_sdrRf = 1'b1;
        w_sdrRd = 1'b0;
        w_sdrWr = (r_state == S_WRITE);
        w_sdrA  = 24'(r_cnt);
        w_sdrD  = {8'd0, bus.initD};
        if (r_state == S_RUN) begin
            w_sdrRf = bus.rfsh;
            w_sdrRd = bus.memR & w_hit;
            w_sdrWr = bus.memW & (w_ram | ((w_page == 8'h07) & bus.memA[13]));
            w_sdrA  = {2'd0, bus.memA};
            w_sdrD  = {8'd0, bus.memD};
`ifdef EP_ROMDL_EN
            // Download owns the write path outright; CPU writes in the same cycle are dropped.
            if (bus.romIo) begin
                w_sdrWr = bus.romW;
                w_sdrA  = {2'd0, bus.romA};
                w_sdrD  = {8'd0, bus.romD};
            end
`endif
        end
    end

    assign bus.initA = r_cnt;
    assign bus.busy  = (r_state != S_RUN);
    assign bus.sdrRf = w_sdrRf;
    assign bus.sdrRd = w_sdrRd;
    assign bus.sdrWr = w_sdrWr;
    assign bus.sdrA  = w_sdrA;
    assign bus.sdrD  = w_sdrD;
    assign bus.memQ  = w_hit ? bus.sdrQ[7:0] : 8'hFF;
    assign bus.romP  = r_romP;
endmodule
